toggle_event_rx: RTL and testbench

- Receive end of a toggle-signalling link: the source flips a T flip-flop output once per event; this block recovers each flip as one event.
- Synchronises the asynchronous toggle level into the local clk domain and edge-detects it into single-cycle pulses.
- Queues detected events as a pending count, offered to a local consumer over a valid/ready handshake.
- Returns an ack toggle level (one flip per accepted event) for the sending side.

---
 rtl/toggle_event_rx_pkg.sv | 14 +
 rtl/toggle_event_rx_sync_chain.sv | 25 ++
 rtl/toggle_event_rx.sv | 110 +++++++++++
 tb/tb_toggle_event_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/toggle_event_rx_pkg.sv
// Shared definitions for toggle-signalling link blocks.
`timescale 1ns/1ps
package toggle_event_rx_pkg;

  // Receiver FSM: PRIME loads the edge detector history, RUN detects edges.
  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Fewest synchroniser flops that still give acceptable MTBF.
  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/toggle_event_rx_sync_chain.sv
// Reset-to-0 shift-register synchroniser for a single asynchronous level.
`timescale 1ns/1ps
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous level through STAGES flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/toggle_event_rx.sv
// Toggle-link receiver: recovers each remote toggle as one event, queues it
// as a pending count behind a valid/ready handshake, and returns an ack toggle.
`timescale 1ns/1ps
module toggle_event_rx
  import toggle_event_rx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              t_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_pulse,
  output logic              ack_q,
  output logic [PEND_W-1:0] pending,
  output logic [CNT_W-1:0]  evt_count,
  output logic              overflow,
  input  logic              clr_ovf
);

  // Values below the minimum are clamped rather than building an unsafe chain.
  localparam int unsigned EFF_STAGES =
    (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
  localparam int unsigned PC_W = $clog2(EFF_STAGES + 1);

  state_e          state;
  logic [PC_W-1:0] prime_cnt;
  logic            sync_out;
  logic            t_prev;
  logic            det;
  logic            acc;
  logic            pend_max;

  sync_chain #(
    .STAGES (EFF_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (t_in),
    .q     (sync_out)
  );

  assign evt_valid = (pending != '0);

  // Edge detect is masked during PRIME; accept needs something pending.
  always_comb begin
    det      = 1'b0;
    acc      = 1'b0;
    pend_max = 1'b0;
    det      = (state == ST_RUN) && (sync_out ^ t_prev);
    acc      = evt_valid && evt_ready;
    pend_max = (pending == {PEND_W{1'b1}});
  end

  // FSM: prime the history with the synchronised level, then run forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_PRIME;
      prime_cnt <= '0;
      t_prev    <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      t_prev    <= sync_out;
      evt_pulse <= det;
      if (state == ST_PRIME) begin
        if (prime_cnt == PC_W'(EFF_STAGES)) begin
          state <= ST_RUN;
        end else begin
          prime_cnt <= prime_cnt + PC_W'(1);
        end
      end
    end
  end

  // Pending queue, ack toggle, event counter and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      ack_q     <= 1'b0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (det && !acc) begin
        if (!pend_max) begin
          pending <= pending + PEND_W'(1);
        end
      end else if (!det && acc) begin
        pending <= pending - PEND_W'(1);
      end

      if (acc) begin
        ack_q <= ~ack_q;
      end

      if (det) begin
        evt_count <= evt_count + CNT_W'(1);
      end

      if (det && !acc && pend_max) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_toggle_event_rx.sv
// Scoreboard bench for toggle_event_rx with directed toggle sequences.
`timescale 1ns/1ps
module tb_toggle_event_rx;

  localparam int unsigned PEND_W = 4;
  localparam int unsigned CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              t_in;
  logic              evt_valid;
  logic              evt_ready;
  logic              evt_pulse;
  logic              ack_q;
  logic [PEND_W-1:0] pending;
  logic [CNT_W-1:0]  evt_count;
  logic              overflow;
  logic              clr_ovf;

  typedef struct {
    int pend;
    int cnt;
    int ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_ack = 0;

  toggle_event_rx #(
    .SYNC_STAGES (2),
    .PEND_W      (PEND_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .t_in      (t_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_pulse (evt_pulse),
    .ack_q     (ack_q),
    .pending   (pending),
    .evt_count (evt_count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every pulse must match the next expected record; extra pulses are errors.
  always @(negedge clk) begin
    if (rst_n && evt_pulse) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pending", int'(pending), e.pend);
        chk("sb_count", int'(evt_count), e.cnt);
        chk("sb_overflow", int'(overflow), e.ovf);
      end
    end
  end

  // One toggle; ready/clr are held only for the edge that registers the pulse.
  task automatic flip_ev(input bit rdy, input bit clr,
                         input int pend, input int cnt, input int ovf);
    exp_t e;
    e.pend = pend;
    e.cnt  = cnt;
    e.ovf  = ovf;
    sb.push_back(e);
    t_in = ~t_in;
    tick();
    tick();
    evt_ready = rdy;
    clr_ovf   = clr;
    tick();
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    t_in      = 1'b1;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;

    // 1: level held high through reset must not produce an event
    repeat (3) tick();
    chk("rst_pending", int'(pending), 0);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_ack", int'(ack_q), 0);
    chk("rst_count", int'(evt_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("prime_pending", int'(pending), 0);
    chk("prime_count", int'(evt_count), 0);
    chk("prime_valid", int'(evt_valid), 0);

    // 2: single event latency and one accept
    sb.push_back('{1, 1, 0});
    t_in = ~t_in;
    tick();
    chk("lat_e0_pulse", int'(evt_pulse), 0);
    tick();
    chk("lat_e1_pulse", int'(evt_pulse), 0);
    tick();
    chk("lat_e2_pulse", int'(evt_pulse), 1);
    chk("lat_e2_valid", int'(evt_valid), 1);
    tick();
    chk("lat_e3_pulse", int'(evt_pulse), 0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    exp_ack = 1;
    chk("acc_pending", int'(pending), 0);
    chk("acc_ack", int'(ack_q), exp_ack);
    chk("acc_valid", int'(evt_valid), 0);
    // ready while empty does nothing
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("empty_ack", int'(ack_q), exp_ack);
    chk("empty_pending", int'(pending), 0);

    // 3: saturate the pending counter
    for (int k = 1; k <= 16; k++) begin
      flip_ev(1'b0, 1'b0, (k > 15) ? 15 : k, 1 + k, (k == 16) ? 1 : 0);
    end
    chk("sat_pending", int'(pending), 15);
    chk("sat_overflow", int'(overflow), 1);
    chk("sat_count", int'(evt_count), 17);

    // 5a: clear with no event
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_overflow", int'(overflow), 0);
    chk("clr_pending", int'(pending), 15);

    // saturated event with simultaneous accept never overflows
    flip_ev(1'b1, 1'b0, 15, 18, 0);
    exp_ack = 0;
    chk("sat_coinc_ack", int'(ack_q), exp_ack);

    // 5b: set wins over clear
    flip_ev(1'b0, 1'b1, 15, 19, 1);
    chk("setclr_overflow", int'(overflow), 1);

    // drain to 3 pending (even number of accepts keeps ack parity)
    evt_ready = 1'b1;
    repeat (12) tick();
    evt_ready = 1'b0;
    chk("drain_pending", int'(pending), 3);
    chk("drain_ack", int'(ack_q), exp_ack);

    // 4: event coinciding with accept at pending=3
    flip_ev(1'b1, 1'b0, 3, 20, 1);
    exp_ack = 1;
    chk("coinc_ack", int'(ack_q), exp_ack);
    chk("coinc_pending", int'(pending), 3);

    // 6: asynchronous reset mid-cycle clears everything before the next edge
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pending", int'(pending), 0);
    chk("arst_ack", int'(ack_q), 0);
    chk("arst_count", int'(evt_count), 0);
    chk("arst_overflow", int'(overflow), 0);
    chk("arst_valid", int'(evt_valid), 0);
    t_in = ~t_in;
    #2;
    rst_n = 1'b1;
    repeat (10) tick();
    chk("reprime_pending", int'(pending), 0);
    chk("reprime_count", int'(evt_count), 0);
    flip_ev(1'b0, 1'b0, 1, 1, 0);

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
